// File: rtl/udp_oe_pkg.sv
// Shared constants, header byte offsets and helpers for the UDP offload engine.
package udp_oe_pkg;

    localparam int          UDP_HDR_BYTES    = 42;
    localparam logic [47:0] ETH_BCAST_MAC    = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ETHERTYPE_IPv4   = 16'h0800;
    localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
    localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
    localparam logic [7:0]  IP_PROTO_UDP     = 8'h11;
    localparam logic [7:0]  IP_VER_IHL       = 8'h45;

    // Byte offsets from the first byte of the Ethernet frame.
    localparam int OFF_ETH_DST   = 0;
    localparam int OFF_ETH_TYPE  = 12;
    localparam int OFF_IP_VIHL   = 14;
    localparam int OFF_IP_PROTO  = 23;
    localparam int OFF_IP_DST    = 30;
    localparam int OFF_UDP_DPORT = 36;
    localparam int OFF_UDP_LEN   = 38;
    localparam int OFF_ARP_HTYPE = 14;
    localparam int OFF_ARP_PTYPE = 16;
    localparam int OFF_ARP_HLEN  = 18;
    localparam int OFF_ARP_PLEN  = 19;
    localparam int OFF_ARP_OPER  = 20;
    localparam int OFF_ARP_SHA   = 22;
    localparam int OFF_ARP_SPA   = 28;
    localparam int OFF_ARP_TPA   = 38;

    typedef logic [UDP_HDR_BYTES*8-1:0] hdr_vec_t;

    typedef enum logic [2:0] {
        ST_HDR      = 3'd0,
        ST_PAYLOAD  = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_ARP_SKIP = 3'd3,
        ST_DROP     = 3'd4
    } rx_state_e;

    function automatic logic [7:0] hdr_byte(input hdr_vec_t h, input int off);
        return h[8*off +: 8];
    endfunction

    function automatic logic [15:0] hdr_get16(input hdr_vec_t h, input int off);
        return {hdr_byte(h, off), hdr_byte(h, off + 1)};
    endfunction

    function automatic logic [31:0] hdr_get32(input hdr_vec_t h, input int off);
        return {hdr_get16(h, off), hdr_get16(h, off + 2)};
    endfunction

    function automatic logic [47:0] hdr_get48(input hdr_vec_t h, input int off);
        return {hdr_get16(h, off), hdr_get32(h, off + 2)};
    endfunction

    function automatic logic [3:0] keep_count(input logic [7:0] keep);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, keep[i]};
        end
        return n;
    endfunction

    function automatic logic [7:0] keep_mask(input logic [3:0] n);
        logic [7:0] k;
        for (int i = 0; i < 8; i++) begin
            k[i] = (i < int'(n));
        end
        return k;
    endfunction

    function automatic logic [63:0] byte_mask(input logic [7:0] keep);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{keep[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/udp_oe_rx_realign.sv
// Two-byte payload realignment: holds bytes 2-7 of the previous beat and merges them
// with bytes 0-1 of the next; drives the registered output stream and its flush beat.
module udp_oe_rx_realign
    import udp_oe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        first_vld_i,
    input  logic [2:0]  first_cnt_i,
    input  logic        beat_vld_i,
    input  logic [3:0]  beat_cnt_i,
    input  logic        beat_final_i,
    input  logic        flush_vld_i,
    input  logic [63:0] data_i,
    input  logic        m_tready_i,
    output logic        out_free_o,
    output logic        m_tvalid_o,
    output logic [63:0] m_tdata_o,
    output logic [7:0]  m_tkeep_o,
    output logic        m_tlast_o
);

    logic [47:0] hold_q, hold_d;
    logic [2:0]  hcnt_q, hcnt_d;
    logic        vld_q, vld_d;
    logic [63:0] dat_q, dat_d;
    logic [7:0]  keep_q, keep_d;
    logic        last_q, last_d;
    logic [3:0]  merge_cnt;

    assign out_free_o = !vld_q || m_tready_i;
    assign merge_cnt  = 4'd6 + ((beat_cnt_i > 4'd2) ? 4'd2 : beat_cnt_i);

    always_comb begin
        hold_d = hold_q;
        hcnt_d = hcnt_q;
        vld_d  = vld_q && !m_tready_i;
        dat_d  = dat_q;
        keep_d = keep_q;
        last_d = last_q;
        if (first_vld_i) begin
            hold_d = data_i[63:16];
            hcnt_d = first_cnt_i;
        end
        if (beat_vld_i) begin
            vld_d  = 1'b1;
            keep_d = keep_mask(merge_cnt);
            dat_d  = {data_i[15:0], hold_q} & byte_mask(keep_mask(merge_cnt));
            last_d = beat_final_i && (beat_cnt_i <= 4'd2);
            hold_d = data_i[63:16];
            hcnt_d = (beat_cnt_i > 4'd2) ? 3'(beat_cnt_i - 4'd2) : 3'd0;
        end
        if (flush_vld_i) begin
            vld_d  = 1'b1;
            keep_d = keep_mask({1'b0, hcnt_q});
            dat_d  = {16'h0000, hold_q} & byte_mask(keep_mask({1'b0, hcnt_q}));
            last_d = 1'b1;
            hcnt_d = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            hcnt_q <= '0;
            vld_q  <= 1'b0;
            dat_q  <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            hcnt_q <= hcnt_d;
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            keep_q <= keep_d;
            last_q <= last_d;
        end
    end

    assign m_tvalid_o = vld_q;
    assign m_tdata_o  = dat_q;
    assign m_tkeep_o  = keep_q;
    assign m_tlast_o  = last_q;

endmodule

// File: rtl/udp_oe_rx_hdr_parser.sv
// RX header parser: qualifies Eth/IPv4/UDP and ARP-request frames against the CSR
// addresses, strips the 42-byte header and forwards the realigned UDP payload.
module udp_oe_rx_hdr_parser
    import udp_oe_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_tvalid,
    output logic                    rx_tready,
    input  logic [DATA_WIDTH-1:0]   rx_tdata,
    input  logic [DATA_WIDTH/8-1:0] rx_tkeep,
    input  logic                    rx_tlast,
    input  logic [47:0]             csr_fpga_mac,
    input  logic [31:0]             csr_fpga_ip,
    input  logic [15:0]             csr_fpga_udp_port,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    output logic                    m_tlast,
    output logic                    arp_req_valid,
    output logic [47:0]             arp_req_sha,
    output logic [31:0]             arp_req_spa,
    output logic [31:0]             rx_good_cnt,
    output logic [31:0]             rx_drop_cnt
);

    rx_state_e    state_q, state_d;
    logic [2:0]   beat_q, beat_d;
    logic [319:0] hdr_q, hdr_d;
    logic [15:0]  rem_q, rem_d;
    logic         tlast_seen_q, tlast_seen_d;
    logic         good_pend_q, good_pend_d;
    logic         arp_vld_q, arp_vld_d;
    logic [47:0]  arp_sha_q, arp_sha_d;
    logic [31:0]  arp_spa_q, arp_spa_d;
    logic [31:0]  good_q, drop_q;
    logic         good_inc, drop_inc;

    logic         first_vld, beat_vld, beat_final, flush_vld, out_free;
    logic         ready_c, rx_fire, is_udp, is_arp;
    hdr_vec_t     hdr_all;
    logic [3:0]   kcnt, take;
    logic [2:0]   avail5, take5;
    logic [15:0]  udp_len, plen;
    logic [47:0]  dmac;

    // Bytes 40-41 live on the current beat when the decision is made at beat 5.
    assign hdr_all = {rx_tdata[15:0], hdr_q};
    assign dmac    = hdr_get48(hdr_all, OFF_ETH_DST);

    assign is_udp = (dmac == csr_fpga_mac)
                 && (hdr_get16(hdr_all, OFF_ETH_TYPE) == ETHERTYPE_IPv4)
                 && (hdr_byte(hdr_all, OFF_IP_VIHL) == IP_VER_IHL)
                 && (hdr_byte(hdr_all, OFF_IP_PROTO) == IP_PROTO_UDP)
                 && (hdr_get32(hdr_all, OFF_IP_DST) == csr_fpga_ip)
                 && (hdr_get16(hdr_all, OFF_UDP_DPORT) == csr_fpga_udp_port);

    assign is_arp = ((dmac == ETH_BCAST_MAC) || (dmac == csr_fpga_mac))
                 && (hdr_get16(hdr_all, OFF_ETH_TYPE) == ETHERTYPE_ARP)
                 && (hdr_get16(hdr_all, OFF_ARP_HTYPE) == 16'h0001)
                 && (hdr_get16(hdr_all, OFF_ARP_PTYPE) == 16'h0800)
                 && (hdr_byte(hdr_all, OFF_ARP_HLEN) == 8'd6)
                 && (hdr_byte(hdr_all, OFF_ARP_PLEN) == 8'd4)
                 && (hdr_get16(hdr_all, OFF_ARP_OPER) == ARP_OPER_REQUEST)
                 && (hdr_get32(hdr_all, OFF_ARP_TPA) == csr_fpga_ip);

    assign kcnt    = keep_count(rx_tkeep);
    assign avail5  = (kcnt > 4'd2) ? 3'(kcnt - 4'd2) : 3'd0;
    assign udp_len = hdr_get16(hdr_all, OFF_UDP_LEN);
    assign plen    = (udp_len >= 16'd8) ? (udp_len - 16'd8) : 16'd0;
    assign take5   = (plen < {13'd0, avail5}) ? plen[2:0] : avail5;
    assign take    = (rem_q < {12'd0, kcnt}) ? rem_q[3:0] : kcnt;

    always_comb begin
        ready_c = 1'b1;
        case (state_q)
            ST_PAYLOAD: ready_c = out_free;
            ST_FLUSH:   ready_c = 1'b0;
            default:    ready_c = 1'b1;
        endcase
    end

    assign rx_tready = !reset && ready_c;
    assign rx_fire   = rx_tvalid && rx_tready;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        hdr_d        = hdr_q;
        rem_d        = rem_q;
        tlast_seen_d = tlast_seen_q;
        good_pend_d  = good_pend_q;
        arp_vld_d    = 1'b0;
        arp_sha_d    = arp_sha_q;
        arp_spa_d    = arp_spa_q;
        good_inc     = 1'b0;
        drop_inc     = 1'b0;
        first_vld    = 1'b0;
        beat_vld     = 1'b0;
        beat_final   = 1'b0;
        flush_vld    = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (rx_fire && beat_q != 3'd5) begin
                    hdr_d[64*beat_q +: 64] = rx_tdata;
                    if (rx_tlast) begin
                        drop_inc = 1'b1;
                        beat_d   = 3'd0;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end else if (rx_fire) begin
                    beat_d = 3'd0;
                    if (is_udp) begin
                        if (take5 == 3'd0) begin
                            // Zero payload: counted as good once the frame is fully consumed.
                            if (rx_tlast) begin
                                good_inc = 1'b1;
                            end else begin
                                good_pend_d = 1'b1;
                                state_d     = ST_DROP;
                            end
                        end else begin
                            first_vld = 1'b1;
                            rem_d     = plen - {13'd0, take5};
                            if (plen == {13'd0, take5} || rx_tlast) begin
                                good_inc     = 1'b1;
                                tlast_seen_d = rx_tlast;
                                state_d      = ST_FLUSH;
                            end else begin
                                state_d = ST_PAYLOAD;
                            end
                        end
                    end else if (is_arp) begin
                        arp_vld_d = 1'b1;
                        arp_sha_d = hdr_get48(hdr_all, OFF_ARP_SHA);
                        arp_spa_d = hdr_get32(hdr_all, OFF_ARP_SPA);
                        if (!rx_tlast) state_d = ST_ARP_SKIP;
                    end else begin
                        drop_inc = 1'b1;
                        if (!rx_tlast) state_d = ST_DROP;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_fire) begin
                    beat_vld   = 1'b1;
                    rem_d      = rem_q - {12'd0, take};
                    beat_final = ({12'd0, take} == rem_q) || rx_tlast;
                    if (beat_final) begin
                        good_inc = 1'b1;
                        if (take > 4'd2) begin
                            tlast_seen_d = rx_tlast;
                            state_d      = ST_FLUSH;
                        end else begin
                            state_d = rx_tlast ? ST_HDR : ST_DROP;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    flush_vld = 1'b1;
                    state_d   = tlast_seen_q ? ST_HDR : ST_DROP;
                end
            end
            ST_ARP_SKIP, ST_DROP: begin
                if (rx_fire && rx_tlast) begin
                    state_d     = ST_HDR;
                    good_inc    = good_pend_q;
                    good_pend_d = 1'b0;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_HDR;
            beat_q       <= '0;
            hdr_q        <= '0;
            rem_q        <= '0;
            tlast_seen_q <= 1'b0;
            good_pend_q  <= 1'b0;
            arp_vld_q    <= 1'b0;
            arp_sha_q    <= '0;
            arp_spa_q    <= '0;
            good_q       <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            hdr_q        <= hdr_d;
            rem_q        <= rem_d;
            tlast_seen_q <= tlast_seen_d;
            good_pend_q  <= good_pend_d;
            arp_vld_q    <= arp_vld_d;
            arp_sha_q    <= arp_sha_d;
            arp_spa_q    <= arp_spa_d;
            if (good_inc && good_q != '1) good_q <= good_q + 32'd1;
            if (drop_inc && drop_q != '1) drop_q <= drop_q + 32'd1;
        end
    end

    udp_oe_rx_realign u_realign (
        .clk          (clk),
        .rst          (reset),
        .first_vld_i  (first_vld),
        .first_cnt_i  (take5),
        .beat_vld_i   (beat_vld),
        .beat_cnt_i   (take),
        .beat_final_i (beat_final),
        .flush_vld_i  (flush_vld),
        .data_i       (rx_tdata),
        .m_tready_i   (m_tready),
        .out_free_o   (out_free),
        .m_tvalid_o   (m_tvalid),
        .m_tdata_o    (m_tdata),
        .m_tkeep_o    (m_tkeep),
        .m_tlast_o    (m_tlast)
    );

    assign arp_req_valid = arp_vld_q;
    assign arp_req_sha   = arp_sha_q;
    assign arp_req_spa   = arp_spa_q;
    assign rx_good_cnt   = good_q;
    assign rx_drop_cnt   = drop_q;

endmodule

// File: tb/tb_udp_oe_rx_hdr_parser.sv
// Directed bench for udp_oe_rx_hdr_parser: UDP forwarding, padding, drops, ARP,
// randomised backpressure over back-to-back frames and mid-frame reset.
module tb_udp_oe_rx_hdr_parser;
    import udp_oe_pkg::*;

    localparam logic [47:0] CSR_MAC  = 48'h0211_2233_4455;
    localparam logic [31:0] CSR_IP   = 32'h0A00_0001;
    localparam logic [15:0] CSR_PORT = 16'd5000;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_tvalid, rx_tready, rx_tlast;
    logic [63:0] rx_tdata;
    logic [7:0]  rx_tkeep;
    logic        m_tvalid, m_tready, m_tlast;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        arp_req_valid;
    logic [47:0] arp_req_sha;
    logic [31:0] arp_req_spa;
    logic [31:0] rx_good_cnt, rx_drop_cnt;

    always #5 clk = ~clk;

    udp_oe_rx_hdr_parser #(.DATA_WIDTH(64)) dut (
        .clk(clk), .reset(reset),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata),
        .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast),
        .csr_fpga_mac(CSR_MAC), .csr_fpga_ip(CSR_IP), .csr_fpga_udp_port(CSR_PORT),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .arp_req_valid(arp_req_valid), .arp_req_sha(arp_req_sha), .arp_req_spa(arp_req_spa),
        .rx_good_cnt(rx_good_cnt), .rx_drop_cnt(rx_drop_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] fb [0:2047];
    int         flen;
    logic [7:0] exp_q[$];
    logic [7:0] out_q[$];
    int         out_beats, out_lasts, arp_pulses, stall_viol;
    logic [7:0] last_keep;
    logic [47:0] arp_sha_seen;
    logic [31:0] arp_spa_seen;
    bit         rand_rdy = 1'b0;

    initial begin
        m_tready = 1'b1;
        forever begin
            @(negedge clk);
            m_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Output collector and stall-rule monitor, sampled mid-cycle.
    initial begin
        logic        prev_stall;
        logic [63:0] prev_dat;
        logic [7:0]  prev_keep;
        logic        prev_last;
        prev_stall = 1'b0;
        prev_dat = '0;
        prev_keep = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_dat ||
                                   m_tkeep !== prev_keep || m_tlast !== prev_last))
                    stall_viol++;
                if (m_tvalid && !m_tready && rx_tready && dut.state_q == ST_PAYLOAD)
                    stall_viol++;
                if (m_tvalid && m_tready) begin
                    out_beats++;
                    for (int i = 0; i < 8; i++)
                        if (m_tkeep[i]) out_q.push_back(m_tdata[8*i +: 8]);
                    if (m_tlast) begin
                        out_lasts++;
                        last_keep = m_tkeep;
                    end
                end
                if (arp_req_valid) begin
                    arp_pulses++;
                    arp_sha_seen = arp_req_sha;
                    arp_spa_seen = arp_req_spa;
                end
            end
            prev_stall = m_tvalid && !m_tready && !reset;
            prev_dat   = m_tdata;
            prev_keep  = m_tkeep;
            prev_last  = m_tlast;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic put8(input logic [7:0] b);
        fb[flen] = b;
        flen++;
    endtask
    task automatic put16(input logic [15:0] v);
        put8(v[15:8]); put8(v[7:0]);
    endtask
    task automatic put32(input logic [31:0] v);
        put16(v[31:16]); put16(v[15:0]);
    endtask
    task automatic put48(input logic [47:0] v);
        put16(v[47:32]); put32(v[31:0]);
    endtask

    task automatic build_udp(input logic [47:0] dmac, input logic [15:0] dport, input int npay,
                             input int pad, input int base, input bit expect_out);
        logic [7:0] b;
        flen = 0;
        put48(dmac); put48(48'h0200_0000_00AA); put16(ETHERTYPE_IPv4);
        put8(8'h45); put8(8'h00); put16(16'(28 + npay)); put16(16'h0); put16(16'h0);
        put8(8'h40); put8(8'h11); put16(16'h0); put32(32'h0A00_0002); put32(CSR_IP);
        put16(16'd1234); put16(dport); put16(16'(8 + npay)); put16(16'h0);
        for (int i = 0; i < npay; i++) begin
            b = 8'(base + i);
            put8(b);
            if (expect_out) exp_q.push_back(b);
        end
        for (int i = 0; i < pad; i++) put8(8'h00);
    endtask

    task automatic build_arp(input logic [47:0] sha, input logic [31:0] spa);
        flen = 0;
        put48(ETH_BCAST_MAC); put48(sha); put16(ETHERTYPE_ARP);
        put16(16'h0001); put16(16'h0800); put8(8'd6); put8(8'd4); put16(ARP_OPER_REQUEST);
        put48(sha); put32(spa); put48(48'h0); put32(CSR_IP);
        while (flen < 60) put8(8'h00);
    endtask

    // Drives fb[0:flen-1]; max_beats > 0 stops early with tvalid left high.
    task automatic send_frame(input int max_beats);
        int nb, guard;
        nb = (flen + 7) / 8;
        if (max_beats > 0 && max_beats < nb) nb = max_beats;
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            rx_tvalid = 1'b1;
            rx_tdata  = '0;
            rx_tkeep  = '0;
            for (int i = 0; i < 8; i++) begin
                if (b * 8 + i < flen) begin
                    rx_tdata[8*i +: 8] = fb[b*8+i];
                    rx_tkeep[i] = 1'b1;
                end
            end
            rx_tlast = (b * 8 + 8 >= flen);
            guard = 0;
            #1;
            while (!rx_tready && guard < 2000) begin
                @(negedge clk);
                #1;
                guard++;
            end
            if (guard >= 2000) begin
                checks++; errors++;
                $display("FAIL rx_tready_timeout: beat %0d never accepted, required acceptance", b);
                return;
            end
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_lasts(input int target);
        int guard;
        guard = 0;
        while (out_lasts < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d tlast beats, required %0d", out_lasts, target);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_obs();
        exp_q.delete();
        out_q.delete();
        out_beats = 0;
        out_lasts = 0;
        arp_pulses = 0;
        last_keep = '0;
    endtask

    function automatic int first_diff();
        if (out_q.size() != exp_q.size()) return (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        foreach (exp_q[i]) if (out_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        rx_tvalid = 1'b0; rx_tdata = '0; rx_tkeep = '0; rx_tlast = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (rx_tready !== 1'b0) begin errors++; $display("FAIL reset_rx_tready: got %b, required 0", rx_tready); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b, required 0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_m_tlast: got %b, required 0", m_tlast); end
        checks++; if (m_tdata !== 64'h0 || m_tkeep !== 8'h0) begin errors++; $display("FAIL reset_m_data: got %h/%h, required 0/0", m_tdata, m_tkeep); end
        checks++; if (arp_req_valid !== 1'b0 || arp_req_sha !== 48'h0 || arp_req_spa !== 32'h0) begin errors++; $display("FAIL reset_arp: got %b %h %h, required zeros", arp_req_valid, arp_req_sha, arp_req_spa); end
        checks++; if (rx_good_cnt !== 32'd0 || rx_drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d, required 0/0", rx_good_cnt, rx_drop_cnt); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (rx_tready !== 1'b1) begin errors++; $display("FAIL idle_rx_tready: got %b, required 1", rx_tready); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_udp_100();
        clear_obs();
        build_udp(CSR_MAC, CSR_PORT, 100, 0, 0, 1'b1);
        send_frame(0);
        idle(2);
        wait_lasts(1);
        checks++; if (out_beats != 13) begin errors++; $display("FAIL udp100_beats: got %0d, required 13", out_beats); end
        checks++; if (last_keep !== 8'h0F) begin errors++; $display("FAIL udp100_last_keep: got %h, required 0f", last_keep); end
        checks++; if (out_lasts != 1) begin errors++; $display("FAIL udp100_tlast_count: got %0d, required 1", out_lasts); end
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL udp100_bytes: first difference at byte %0d, got %0d bytes, required %0d", first_diff(), out_q.size(), exp_q.size()); end
        checks++; if (rx_good_cnt !== 32'd1 || rx_drop_cnt !== 32'd0) begin errors++; $display("FAIL udp100_counters: got %0d/%0d, required 1/0", rx_good_cnt, rx_drop_cnt); end
    endtask

    task automatic test_min_frame();
        clear_obs();
        build_udp(CSR_MAC, CSR_PORT, 4, 14, 8'hA0, 1'b1);
        send_frame(0);
        idle(2);
        wait_lasts(1);
        checks++; if (out_beats != 1 || last_keep !== 8'h0F) begin errors++; $display("FAIL min_frame_beat: got %0d beats keep %h, required 1 beat keep 0f", out_beats, last_keep); end
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL min_frame_bytes: got %0d bytes, required %0d without pad", out_q.size(), exp_q.size()); end
        checks++; if (rx_good_cnt !== 32'd2) begin errors++; $display("FAIL min_frame_good: got %0d, required 2", rx_good_cnt); end
    endtask

    task automatic test_bad_port();
        clear_obs();
        build_udp(CSR_MAC, 16'd5001, 20, 0, 8'h10, 1'b0);
        send_frame(0);
        build_udp(CSR_MAC, CSR_PORT, 20, 0, 8'h40, 1'b1);
        send_frame(0);
        idle(2);
        wait_lasts(1);
        checks++; if (rx_drop_cnt !== 32'd1) begin errors++; $display("FAIL bad_port_drop: got %0d, required 1", rx_drop_cnt); end
        checks++; if (out_lasts != 1 || out_beats != 3) begin errors++; $display("FAIL bad_port_frames: got %0d frames %0d beats, required 1 frame 3 beats", out_lasts, out_beats); end
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL bad_port_follow_bytes: got %0d bytes, required %0d", out_q.size(), exp_q.size()); end
        checks++; if (rx_good_cnt !== 32'd3) begin errors++; $display("FAIL bad_port_good: got %0d, required 3", rx_good_cnt); end
    endtask

    task automatic test_runt();
        clear_obs();
        flen = 0;
        put48(CSR_MAC);
        for (int i = 0; i < 24; i++) put8(8'(i));
        send_frame(0);
        build_udp(CSR_MAC, CSR_PORT, 9, 9, 8'h77, 1'b1);
        send_frame(0);
        idle(2);
        wait_lasts(1);
        checks++; if (rx_drop_cnt !== 32'd2) begin errors++; $display("FAIL runt_drop: got %0d, required 2", rx_drop_cnt); end
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL runt_follow_bytes: got %0d bytes, required %0d", out_q.size(), exp_q.size()); end
        checks++; if (rx_good_cnt !== 32'd4) begin errors++; $display("FAIL runt_good: got %0d, required 4", rx_good_cnt); end
    endtask

    task automatic test_arp();
        clear_obs();
        build_arp(48'h0200_0000_0001, 32'h0A00_0002);
        send_frame(0);
        idle(10);
        checks++; if (arp_pulses != 1) begin errors++; $display("FAIL arp_pulse: got %0d cycles, required 1", arp_pulses); end
        checks++; if (arp_sha_seen !== 48'h0200_0000_0001) begin errors++; $display("FAIL arp_sha: got %h, required 020000000001", arp_sha_seen); end
        checks++; if (arp_spa_seen !== 32'h0A00_0002) begin errors++; $display("FAIL arp_spa: got %h, required 0a000002", arp_spa_seen); end
        checks++; if (arp_req_sha !== 48'h0200_0000_0001) begin errors++; $display("FAIL arp_sha_hold: got %h, required 020000000001", arp_req_sha); end
        checks++; if (out_beats != 0) begin errors++; $display("FAIL arp_no_output: got %0d beats, required 0", out_beats); end
        checks++; if (rx_good_cnt !== 32'd4 || rx_drop_cnt !== 32'd2) begin errors++; $display("FAIL arp_counters: got %0d/%0d, required 4/2", rx_good_cnt, rx_drop_cnt); end
    endtask

    task automatic test_back_to_back();
        int np, pad, nlast;
        clear_obs();
        stall_viol = 0;
        nlast = 0;
        rand_rdy = 1'b1;
        for (int f = 0; f < 50; f++) begin
            np  = (f * 23) % 90;
            pad = (np < 18) ? 18 - np : 0;
            if (np > 0) nlast++;
            build_udp(CSR_MAC, CSR_PORT, np, pad, f * 7, 1'b1);
            send_frame(0);
        end
        idle(2);
        wait_lasts(nlast);
        rand_rdy = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL b2b_stream: first difference at byte %0d, got %0d bytes, required %0d", first_diff(), out_q.size(), exp_q.size()); end
        checks++; if (out_lasts != nlast) begin errors++; $display("FAIL b2b_frames: got %0d, required %0d", out_lasts, nlast); end
        checks++; if (rx_good_cnt !== 32'd54 || rx_drop_cnt !== 32'd2) begin errors++; $display("FAIL b2b_counters: got %0d/%0d, required 54/2", rx_good_cnt, rx_drop_cnt); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL b2b_stall_rules: got %0d violations, required 0", stall_viol); end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        build_udp(CSR_MAC, CSR_PORT, 100, 0, 8'h30, 1'b0);
        send_frame(9);
        @(negedge clk);
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        reset     = 1'b1;
        #1;
        checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tkeep !== 8'h0 || m_tdata !== 64'h0) begin errors++; $display("FAIL midreset_output: got v%b l%b k%h d%h, required zeros", m_tvalid, m_tlast, m_tkeep, m_tdata); end
        checks++; if (rx_good_cnt !== 32'd0 || rx_drop_cnt !== 32'd0) begin errors++; $display("FAIL midreset_counters: got %0d/%0d, required 0/0", rx_good_cnt, rx_drop_cnt); end
        checks++; if (rx_tready !== 1'b0 || arp_req_valid !== 1'b0) begin errors++; $display("FAIL midreset_ready_arp: got %b/%b, required 0/0", rx_tready, arp_req_valid); end
        checks++; if (out_lasts != 0) begin errors++; $display("FAIL midreset_no_tlast: got %0d, required 0", out_lasts); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        clear_obs();
        build_udp(CSR_MAC, CSR_PORT, 20, 0, 8'hC0, 1'b1);
        send_frame(0);
        idle(2);
        wait_lasts(1);
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL midreset_next_bytes: got %0d bytes, required %0d", out_q.size(), exp_q.size()); end
        checks++; if (rx_good_cnt !== 32'd1 || out_lasts != 1) begin errors++; $display("FAIL midreset_next_frame: got good %0d frames %0d, required 1/1", rx_good_cnt, out_lasts); end
    endtask

    initial begin
        stall_viol = 0;
        clear_obs();
        test_reset();
        test_udp_100();
        test_min_frame();
        test_bad_port();
        test_runt();
        test_arp();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
